// File: rtl/uart_pkg.sv
// Shared types for the UART receive path (and later the transmit path).
//   parity_mode_e : encoding of the PARITY_MODE parameter
//   rx_state_e    : receiver FSM states
//   rx_frame_t    : one received frame as stored in the receive FIFO
//   majority3     : 2-of-3 vote used for per-bit sample filtering
package uart_pkg;

    // Frame storage is sized for the widest legal word; narrower
    // configurations leave the upper data bits at zero.
    localparam int MAX_BYTESIZES = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    typedef struct packed {
        logic [MAX_BYTESIZES-1:0] data;
        logic                     parity_err;
        logic                     frame_err;
    } rx_frame_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// System-side handshake of the UART receiver.
//   master : the receiver (drives valid/data/errors/overrun, reads ready)
//   slave  : the consumer
interface uart_rx_cfg_if #(
    parameter int BYTESIZES = 8
) ();
    logic                 ready_rx_in;
    logic                 valid_rx_out;
    logic [BYTESIZES-1:0] data_rx_out;
    logic                 parity_err_out;
    logic                 frame_err_out;
    logic                 overrun_out;

    modport master (
        input  ready_rx_in,
        output valid_rx_out, data_rx_out, parity_err_out, frame_err_out, overrun_out
    );

    modport slave (
        output ready_rx_in,
        input  valid_rx_out, data_rx_out, parity_err_out, frame_err_out, overrun_out
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with the head exposed combinationally from registers.
//   push_i/din_i : write (ignored when full unless a pop happens the same cycle)
//   pop_i        : remove head (ignored when empty)
//   full_o/empty_o, head_o : status and current head entry
module uart_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchroniser, oversampled bit
// timing with 3-sample majority vote, optional parity, 1/2 stop bits,
// and a receive FIFO with valid/ready output and overrun pulse.
//   clock, nreset : system clock, async active-low reset
//   sdata_rx_in   : serial line (idle high, asynchronous)
//   rx_if         : consumer handshake (valid/ready, data, error flags, overrun)
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BYTESIZES           = 8,
    parameter int OVERSAMPLING        = 16,
    parameter int BAUDRATE            = 9600,
    parameter int COUNTER_CLOCK_INPUT = 50_000_000,
    parameter int PARITY_MODE         = 0,
    parameter int STOP_BITS           = 1,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          sdata_rx_in,
    uart_rx_cfg_if.master rx_if
);
    localparam int DIV = COUNTER_CLOCK_INPUT / (BAUDRATE * OVERSAMPLING);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLING);
    localparam int BW  = $clog2(BYTESIZES + 1);
    localparam int M   = OVERSAMPLING / 2;
    localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE[1:0]);

    if (DIV < 1 || BYTESIZES < 5 || BYTESIZES > MAX_BYTESIZES || OVERSAMPLING < 4 ||
        (OVERSAMPLING % 2) != 0 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic                 rx_meta_q, rxs_q;
    rx_state_e            state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [SW-1:0]        samp_q;
    logic [1:0]           smp_q;       // [1]: sample M-1, [0]: sample M
    logic [BYTESIZES-1:0] shift_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 par_err_q, frm_err_q;
    logic                 overrun_q;
    logic [BYTESIZES-1:0] hold_q;

    logic      tick, dec_en, bit_val, exp_par, last_stop;
    logic      push_w, pop_w, fifo_full, fifo_empty;
    rx_frame_t push_frame, head_frame;

    assign tick      = (tick_cnt_q == TW'(DIV - 1));
    // The bit is decided on the third vote sample, using the live value.
    assign dec_en    = tick && (samp_q == SW'(M + 1));
    assign bit_val   = majority3(smp_q[1], smp_q[0], rxs_q);
    assign exp_par   = (PMODE == PAR_ODD) ? ~(^shift_q) : ^shift_q;
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
    assign push_w    = (state_q == STOP) && dec_en && last_stop;
    assign pop_w     = rx_if.valid_rx_out && rx_if.ready_rx_in;

    always_comb begin
        push_frame                      = '0;
        push_frame.data[BYTESIZES-1:0]  = shift_q;
        push_frame.parity_err           = par_err_q;
        push_frame.frame_err            = frm_err_q | ~bit_val;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_meta_q <= sdata_rx_in;
            rxs_q     <= rx_meta_q;
            if (state_q == IDLE) begin
                // Timing restarts from the first low sample of the start bit.
                tick_cnt_q <= '0;
                samp_q     <= '0;
                if (!rxs_q) begin
                    state_q    <= START;
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    par_err_q  <= 1'b0;
                    frm_err_q  <= 1'b0;
                end
            end else begin
                tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    samp_q <= (samp_q == SW'(OVERSAMPLING - 1)) ? '0 : samp_q + SW'(1);
                    if (samp_q == SW'(M - 1)) smp_q[1] <= rxs_q;
                    if (samp_q == SW'(M))     smp_q[0] <= rxs_q;
                end
                if (dec_en) begin
                    case (state_q)
                        START: state_q <= bit_val ? IDLE : DATA;
                        DATA: begin
                            shift_q   <= {bit_val, shift_q[BYTESIZES-1:1]};
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BW'(BYTESIZES - 1))
                                state_q <= (PMODE != PAR_NONE) ? PARITY : STOP;
                        end
                        PARITY: begin
                            if (bit_val != exp_par) par_err_q <= 1'b1;
                            state_q <= STOP;
                        end
                        STOP: begin
                            if (!bit_val) frm_err_q <= 1'b1;
                            if (last_stop) state_q <= bit_val ? IDLE : BREAK_WAIT;
                            else           stop_cnt_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // A held-low line must go high before another start is accepted.
                if (state_q == BREAK_WAIT && rxs_q) state_q <= IDLE;
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH ($bits(rx_frame_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (nreset),
        .push_i  (push_w),
        .din_i   (push_frame),
        .pop_i   (pop_w),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_frame)
    );

    // hold_q keeps the last delivered word visible once the FIFO drains.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            overrun_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            overrun_q <= push_w && fifo_full && !pop_w;
            if (pop_w) hold_q <= head_frame.data[BYTESIZES-1:0];
        end
    end

    assign rx_if.valid_rx_out   = !fifo_empty;
    assign rx_if.data_rx_out    = fifo_empty ? hold_q : head_frame.data[BYTESIZES-1:0];
    assign rx_if.parity_err_out = head_frame.parity_err;
    assign rx_if.frame_err_out  = head_frame.frame_err;
    assign rx_if.overrun_out    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg. Three instances cover the configurations:
//   u0: no parity, 1 stop   u1: even parity, 1 stop   u2: no parity, 2 stops
// 16 MHz / (1 Mbaud * 16) -> one sample per clock, 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    uart_rx_cfg_if #(.BYTESIZES(8)) if0 ();
    uart_rx_cfg_if #(.BYTESIZES(8)) if1 ();
    uart_rx_cfg_if #(.BYTESIZES(8)) if2 ();

    uart_rx_cfg #(.BYTESIZES(8), .OVERSAMPLING(16), .BAUDRATE(1_000_000),
                  .COUNTER_CLOCK_INPUT(16_000_000), .PARITY_MODE(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4))
        u0 (.clock(clock), .nreset(nreset), .sdata_rx_in(rx0), .rx_if(if0.master));
    uart_rx_cfg #(.BYTESIZES(8), .OVERSAMPLING(16), .BAUDRATE(1_000_000),
                  .COUNTER_CLOCK_INPUT(16_000_000), .PARITY_MODE(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4))
        u1 (.clock(clock), .nreset(nreset), .sdata_rx_in(rx1), .rx_if(if1.master));
    uart_rx_cfg #(.BYTESIZES(8), .OVERSAMPLING(16), .BAUDRATE(1_000_000),
                  .COUNTER_CLOCK_INPUT(16_000_000), .PARITY_MODE(0), .STOP_BITS(2),
                  .FIFO_DEPTH(4))
        u2 (.clock(clock), .nreset(nreset), .sdata_rx_in(rx2), .rx_if(if2.master));

    // Accepted frames {data, parity_err, frame_err}, overrun pulses, valid cycles.
    logic [9:0] q0[$], q1[$], q2[$];
    int ovr0 = 0, vcnt0 = 0;

    always @(negedge clock) begin
        if (if0.valid_rx_out && if0.ready_rx_in)
            q0.push_back({if0.data_rx_out, if0.parity_err_out, if0.frame_err_out});
        if (if1.valid_rx_out && if1.ready_rx_in)
            q1.push_back({if1.data_rx_out, if1.parity_err_out, if1.frame_err_out});
        if (if2.valid_rx_out && if2.ready_rx_in)
            q2.push_back({if2.data_rx_out, if2.parity_err_out, if2.frame_err_out});
        if (if0.overrun_out)  ovr0++;
        if (if0.valid_rx_out) vcnt0++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic b);
        case (ch)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
        repeat (16) @(posedge clock);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send(input int ch, input logic [7:0] d, input int par,
                        input logic s1, input logic s2, input int nstop);
        drive(ch, 1'b0);
        for (int i = 0; i < 8; i++) drive(ch, d[i]);
        if (par >= 0) drive(ch, par[0]);
        drive(ch, s1);
        if (nstop == 2) drive(ch, s2);
    endtask

    task automatic idle_bits(input int ch, input int n);
        for (int i = 0; i < n; i++) drive(ch, 1'b1);
    endtask

    initial begin
        int b0, b1, b2, v0, o0;
        if0.ready_rx_in = 1'b1;
        if1.ready_rx_in = 1'b1;
        if2.ready_rx_in = 1'b1;

        // Reset state
        repeat (4) @(posedge clock);
        #1;
        chk("rst_valid",   32'(if0.valid_rx_out),   32'd0);
        chk("rst_data",    32'(if0.data_rx_out),    32'd0);
        chk("rst_perr",    32'(if0.parity_err_out), 32'd0);
        chk("rst_ferr",    32'(if0.frame_err_out),  32'd0);
        chk("rst_overrun", 32'(if0.overrun_out),    32'd0);
        @(negedge clock) nreset = 1'b1;
        idle_bits(0, 2);

        // 1. 0xA5, no parity, one stop
        b0 = q0.size(); v0 = vcnt0;
        send(0, 8'hA5, -1, 1'b1, 1'b1, 1);
        idle_bits(0, 2);
        chk("t1_count",  32'(q0.size() - b0), 32'd1);
        chk("t1_vcycles", 32'(vcnt0 - v0),    32'd1);
        chk("t1_frame",  32'(q0[b0]), 32'({8'hA5, 1'b0, 1'b0}));

        // 2. Even parity: 0x07 needs parity bit 1
        b1 = q1.size();
        send(1, 8'h07, 0, 1'b1, 1'b1, 1);
        idle_bits(1, 2);
        send(1, 8'h07, 1, 1'b1, 1'b1, 1);
        idle_bits(1, 2);
        chk("t2_count",  32'(q1.size() - b1), 32'd2);
        chk("t2_badpar", 32'(q1[b1]),     32'({8'h07, 1'b1, 1'b0}));
        chk("t2_goodpar", 32'(q1[b1 + 1]), 32'({8'h07, 1'b0, 1'b0}));

        // 3. Two stops, second stop low, then line held low ~40 bit times
        b2 = q2.size();
        send(2, 8'h3C, -1, 1'b1, 1'b0, 2);
        for (int i = 0; i < 39; i++) drive(2, 1'b0);
        chk("t3_count_low", 32'(q2.size() - b2), 32'd1);
        chk("t3_frame",     32'(q2[b2]), 32'({8'h3C, 1'b0, 1'b1}));
        idle_bits(2, 3);
        chk("t3_count_high", 32'(q2.size() - b2), 32'd1);
        send(2, 8'h55, -1, 1'b1, 1'b1, 2);
        idle_bits(2, 2);
        chk("t3_count_next", 32'(q2.size() - b2), 32'd2);
        chk("t3_next_frame", 32'(q2[b2 + 1]), 32'({8'h55, 1'b0, 1'b0}));

        // 4. Four-clock glitch on an idle line is a false start
        b0 = q0.size(); v0 = vcnt0;
        rx0 = 1'b0;
        repeat (4) @(posedge clock);
        rx0 = 1'b1;
        idle_bits(0, 3);
        chk("t4_count",   32'(q0.size() - b0), 32'd0);
        chk("t4_vcycles", 32'(vcnt0 - v0),     32'd0);

        // 5. Overrun: five back-to-back frames into a 4-deep FIFO with ready low
        if0.ready_rx_in = 1'b0;
        o0 = ovr0;
        for (int k = 1; k <= 5; k++) send(0, 8'(k), -1, 1'b1, 1'b1, 1);
        idle_bits(0, 2);
        chk("t5_overrun", 32'(ovr0 - o0), 32'd1);
        chk("t5_valid",   32'(if0.valid_rx_out), 32'd1);
        chk("t5_head",    32'(if0.data_rx_out),  32'h01);
        repeat (20) @(posedge clock);
        #1;
        chk("t5_head_stable", 32'(if0.data_rx_out), 32'h01);
        b0 = q0.size();
        @(negedge clock) if0.ready_rx_in = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("t5_popped", 32'(q0.size() - b0), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t5_pop%0d", k), 32'(q0[b0 + k]), 32'({8'(k + 1), 1'b0, 1'b0}));
        chk("t5_empty_hold", 32'(if0.data_rx_out), 32'h04);

        // 6. Reset mid-frame flushes the FIFO and drops the partial frame
        if0.ready_rx_in = 1'b0;
        send(0, 8'h11, -1, 1'b1, 1'b1, 1);
        idle_bits(0, 1);
        chk("t6_preload", 32'(if0.valid_rx_out), 32'd1);
        drive(0, 1'b0);          // start of 0x5A
        drive(0, 1'b0);          // bit0
        drive(0, 1'b1);          // bit1
        rx0 = 1'b0;              // bit2, interrupted by reset
        repeat (8) @(posedge clock);
        @(negedge clock) nreset = 1'b0;
        rx0 = 1'b1;
        repeat (3) @(negedge clock);
        nreset = 1'b1;
        #1;
        chk("t6_flush_valid", 32'(if0.valid_rx_out), 32'd0);
        chk("t6_flush_data",  32'(if0.data_rx_out),  32'd0);
        b0 = q0.size();
        if0.ready_rx_in = 1'b1;
        idle_bits(0, 2);
        send(0, 8'hC3, -1, 1'b1, 1'b1, 1);
        idle_bits(0, 2);
        chk("t6_count", 32'(q0.size() - b0), 32'd1);
        chk("t6_frame", 32'(q0[b0]), 32'({8'hC3, 1'b0, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to uart_rx. It adds configurable parity (none/even/odd), 1 or 2 stop bits, and 3-sample majority voting per bit. It reports parity and framing errors per frame and buffers received frames in an internal FIFO with a valid/ready output handshake plus overrun reporting. It sits between the serial pin and the system-side consumer, in the same clock domain as the consumer.

Parameters:
BYTESIZES, 8, data bits per frame (5..9), LSB first
OVERSAMPLING, 16, samples per bit (>=4, even)
BAUDRATE, 9600, line bit rate
COUNTER_CLOCK_INPUT, 50_000_000, clock frequency in Hz
PARITY_MODE, 0, 0=none, 1=even, 2=odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clock  input  1  system clock, single domain
nreset  input  1  asynchronous, active-low reset
sdata_rx_in  input  1  serial line, idle high, asynchronous to clock
ready_rx_in  input  1  consumer accepts FIFO head
valid_rx_out  output  1  FIFO not empty
data_rx_out  output  BYTESIZES  FIFO head data
parity_err_out  output  1  head frame had a parity mismatch (0 when PARITY_MODE=0)
frame_err_out  output  1  head frame had a stop bit sampled as 0
overrun_out  output  1  one-cycle pulse: a completed frame was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert): valid_rx_out=0, data_rx_out=0, both error outputs=0, overrun_out=0, FIFO empty, state IDLE, synchroniser flops=1.
- Synchroniser: 2-flop on sdata_rx_in. All logic uses the synchronised value (rxs).
- Sample tick: DIV = COUNTER_CLOCK_INPUT/(BAUDRATE*OVERSAMPLING), truncated. Elaboration error if DIV<1. Tick counter counts 0..DIV-1 and ticks on DIV-1. Sample counter counts 0..OVERSAMPLING-1 per bit. Both counters clear when IDLE detects rxs=0.
- Majority: each bit value = majority of rxs at sample indices M-1, M, M+1, where M=OVERSAMPLING/2. The bit is decided at index M+1.
- State machine:
  - IDLE: on rxs=0 -> START.
  - START: decided bit=1 -> IDLE (false start, nothing pushed). Decided bit=0 -> DATA.
  - DATA: shift in BYTESIZES bits LSB first. After the last bit -> PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: compare the decided bit with the expected value. Even: XOR of data. Odd: inverted XOR of data. Mismatch sets the parity error flag. -> STOP.
  - STOP: decide STOP_BITS bits; any 0 sets frame_err. At the decision point of the last stop bit, push {data, parity_err, frame_err}. Then go -> IDLE if the last stop bit=1, else -> BREAK_WAIT.
  - BREAK_WAIT: stay until rxs=1, then -> IDLE. A held-low line therefore yields exactly one errored frame.
- Back-to-back frames: returning to IDLE at mid-stop allows a start edge immediately after the stop bit.
- FIFO:
  - Push at the last stop-bit decision.
  - Pop when valid_rx_out && ready_rx_in.
  - Outputs show the head combinationally from registered storage. valid_rx_out rises the cycle after the push.
  - Full with push and pop in the same cycle: both occur, no overrun.
  - Full with push and no pop: frame discarded, overrun_out=1 for one cycle, FIFO contents unchanged.
  - Empty: data_rx_out holds the last value; the error outputs are don't-care when valid_rx_out=0.
- Reset mid-frame: partial frame discarded, FIFO flushed.
- Data held stable while valid_rx_out=1 && ready_rx_in=0.

Decomposition:
- Package uart_pkg:
  - parity_mode_e (PAR_NONE, PAR_EVEN, PAR_ODD)
  - rx_state_e (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT)
  - rx_frame_t struct (data, parity_err, frame_err), parametrised via BYTESIZES
  - function majority3
- Sub-module: uart_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/head). Reused later by the transmit path.

Test Plan:
Bench config: COUNTER_CLOCK_INPUT=16_000_000, BAUDRATE=1_000_000, OVERSAMPLING=16 -> DIV=1, 16 clocks per bit.
1. PARITY_MODE=0, send 0xA5 with 1 stop bit, ready_rx_in=1 -> exactly one valid cycle with data=0xA5, both errors 0.
2. PARITY_MODE=1, send 0x07 with parity bit 0 (wrong) -> data=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
3. STOP_BITS=2, send 0x3C with second stop bit=0, then hold the line low for 40 bit times -> exactly one entry, frame_err=1, data=0x3C. No further entries until the line returns high and a new frame is sent.
4. 0-glitch of 4 clocks on an idle line -> false start, no push, valid_rx_out stays 0.
5. FIFO_DEPTH=4, ready_rx_in=0, send 0x01..0x05 back-to-back -> overrun_out pulses once at the 5th frame. Raising ready then pops 0x01,0x02,0x03,0x04 in order.
6. Assert nreset mid-DATA of 0x5A, release, then send 0xC3 -> only 0xC3 is output.
